axis_sink_checker: RTL and testbench
====================================

# axis_sink_checker

Receive-side AXI-Stream endpoint for the mesh traffic experiments: consumes packets delivered to one NoC node, checks their framing and routing, and reports counts, a per-packet XOR checksum and error status. It is the counterpart of the LFSR-driven traffic generator: the generator drives the mesh master ports, and this block terminates a mesh slave port. Optional pseudo-random backpressure exercises flow control in the mesh.

## Interface
- `TDATAW`, 32, data width; `TDATA` is `[TDATAW-1:0]`
- `TDESTW`, 4, destination field width
- `TIDW`, 2, source ID field width
- `NODE_ID`, 0, this node's address; every accepted `TDEST` must equal it
- `MAX_BEATS`, 16, maximum legal beats per packet (≥1)
- `CNTW`, 16, width of the status counters
- `LFSR_DW`, 7, stall LFSR width
- `LFSR_DEFAULT`, 7'h01, stall LFSR seed (nonzero)

- `CLK` in 1 — single clock
- `RST_N` in 1 — asynchronous, active-low reset
- `ENABLE` in 1 — allows acceptance
- `CLR` in 1 — synchronous clear of counters and state
- `STALL_EN` in 1 — enables pseudo-random `TREADY` deassertion
- `AXIS_S_TVALID` in 1; `AXIS_S_TREADY` out 1; `AXIS_S_TDATA` in `TDATAW`; `AXIS_S_TLAST` in 1; `AXIS_S_TID` in `TIDW`; `AXIS_S_TDEST` in `TDESTW` — AXI-Stream slave
- `PKT_CNT` out `CNTW` — good packets received
- `ERR_CNT` out `CNTW` — errored packets
- `BEAT_CNT` out `CNTW` — all accepted beats
- `CHECKSUM` out `TDATAW` — XOR of all beats of the last completed packet
- `LAST_TID` out `TIDW` — TID of the last completed packet
- `LAST_ERR` out 2 — code of the most recent error: 0 none, 1 dest, 2 TID change, 3 overlength
- `PKT_DONE` out 1 — one-cycle pulse per completed packet, good or bad
- `BUSY` out 1 — high while mid-packet (state ≠ IDLE)

## Operation
- Beat accepted when `TVALID & TREADY` at a rising edge.
- `TREADY` is registered: next value = `ENABLE & ~CLR & ~(STALL_EN & lfsr[0])`. It may drop with `TVALID` high.
- The LFSR advances every cycle while `STALL_EN`=1 and holds otherwise.
- FSM:
  - **IDLE**: on an accepted beat, latch TID, beat count = 1, and `acc = TDATA`.
    - Dest mismatch → error 1.
    - With `TLAST` → complete the packet and stay in IDLE.
    - Otherwise → BODY, or DROP on error.
  - **BODY**: each accepted beat does `acc ^= TDATA` and `beats++`.
    - Dest mismatch → error 1; TID ≠ latched TID → error 2; `beats` would exceed `MAX_BEATS` → error 3. Priority is 1 > 2 > 3.
    - On error → DROP, or complete immediately if `TLAST`.
    - On `TLAST` without error → complete, go to IDLE.
  - **DROP**: accept and discard beats until `TLAST`, then complete as errored and go to IDLE.
- Completion:
  - Good packet: `PKT_CNT++`, `CHECKSUM ← acc`, `LAST_TID` updated.
  - Errored packet: `ERR_CNT++` exactly once per packet, `LAST_ERR` updated; `CHECKSUM` is unchanged.
  - `PKT_DONE` pulses in both cases.
- `BEAT_CNT` increments on every accepted beat, including in DROP.
- All counters saturate at all-ones and never wrap.

## Timing
- Reset values: `TREADY`=0, all counters 0, `CHECKSUM`=0, `LAST_TID`=0, `LAST_ERR`=0, `PKT_DONE`=0, `BUSY`=0, state IDLE, LFSR = `LFSR_DEFAULT`.
- First `TREADY`=1 appears one cycle after reset release with `ENABLE`=1.
- Counters, `CHECKSUM` and `PKT_DONE` update on the edge that accepts `TLAST`; the values are visible the following cycle.
- A single-beat packet completes in 1 cycle, and back-to-back packets are accepted at full rate.
- `CLR`:
  - Zeroes counters and status and forces IDLE at the next edge.
  - `TREADY` is 0 the cycle after.
  - A beat presented at the `CLR` edge is not accepted.
  - `CLR` has priority over a simultaneous accept.
- `ENABLE` low mid-packet: `TREADY` drops next cycle and the state is held; the packet resumes when `ENABLE` returns.
- Reset mid-packet: immediate return to reset values; the partial packet is not counted.

## Structure
- Shared package `noc_axis_pkg`:
  - state enum `sink_state_t` (IDLE, BODY, DROP);
  - error code enum `sink_err_t`;
  - widths shared with the generator.
- One sub-module: the existing `lfsr` (parameters `LFSR_DW`, `LFSR_DEFAULT`) instantiated as the stall source, with a clock enable tied to `STALL_EN`.

## Test plan
- 4-beat packet, `TDEST`=`NODE_ID`, TID 1, data 1,2,4,8 → `PKT_CNT`=1, `CHECKSUM`=0xF, `LAST_TID`=1, `BEAT_CNT`=4, one `PKT_DONE`.
- Single-beat packet with `TDEST`=`NODE_ID`+1 → `ERR_CNT`=1, `LAST_ERR`=1, `PKT_CNT`=0, FSM back in IDLE.
- 20-beat packet with `MAX_BEATS`=16 → error 3 at beat 17, beats 18–20 accepted in DROP, `ERR_CNT`=1, `BEAT_CNT`=20.
- TID changes 1→2 at beat 2 of 3 → `LAST_ERR`=2, `ERR_CNT`=1, `CHECKSUM` unchanged.
- `STALL_EN`=1, 100 random packets → no beat lost or duplicated, `PKT_CNT`=100, `TREADY` low on some cycles.
- `CLR` asserted mid-packet → counters 0, `BUSY`=0 the next cycle; the following packet is counted correctly.

Source files
------------

// File: rtl/noc_axis_pkg.sv
// Shared types and widths for the mesh AXI-Stream traffic generator and sink checker.
// Combinational definitions only: no latency, no flow control.
// Backpressure: not applicable.
package noc_axis_pkg;

    localparam int AXIS_TDATAW = 32;
    localparam int AXIS_TDESTW = 4;
    localparam int AXIS_TIDW   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BODY = 2'd1,
        ST_DROP = 2'd2
    } sink_state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_DEST = 2'd1,
        ERR_TID  = 2'd2,
        ERR_LEN  = 2'd3
    } sink_err_t;

    // Galois feedback masks for maximal-length right-shifting LFSRs
    function automatic logic [31:0] lfsr_taps(input int w);
        case (w)
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            16:      return 32'h0000_B400;
            default: return 32'h0000_0060;
        endcase
    endfunction

endpackage

// File: rtl/lfsr.sv
// Galois LFSR with clock enable; exposes the low state bit as a pseudo-random stream.
// Output registered, changes one cycle after each enabled edge.
// Backpressure: none; holds state while EN is low.
module lfsr
    import noc_axis_pkg::*;
#(
    parameter int                 LFSR_DW      = 7,
    parameter logic [LFSR_DW-1:0] LFSR_DEFAULT = {{(LFSR_DW-1){1'b0}}, 1'b1}
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic EN,
    output logic BIT_O
);

    localparam logic [LFSR_DW-1:0] TAPS = LFSR_DW'(lfsr_taps(LFSR_DW));

    logic [LFSR_DW-1:0] lfsr_q;
    logic [LFSR_DW-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lfsr_q <= LFSR_DEFAULT;
        end else if (EN) begin
            lfsr_q <= lfsr_d;
        end
    end

    assign BIT_O = lfsr_q[0];

endmodule

// File: rtl/axis_sink_checker.sv
// AXI-Stream sink for a NoC node: checks dest/TID/length framing, counts packets, XORs payload.
// Single-beat packets complete in one cycle; status visible the cycle after the TLAST accept.
// TREADY is registered; drops on ~ENABLE, CLR, or pseudo-random stall when STALL_EN is set.
module axis_sink_checker
    import noc_axis_pkg::*;
#(
    parameter int                 TDATAW       = AXIS_TDATAW,
    parameter int                 TDESTW       = AXIS_TDESTW,
    parameter int                 TIDW         = AXIS_TIDW,
    parameter int                 NODE_ID      = 0,
    parameter int                 MAX_BEATS    = 16,
    parameter int                 CNTW         = 16,
    parameter int                 LFSR_DW      = 7,
    parameter logic [LFSR_DW-1:0] LFSR_DEFAULT = 7'h01
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              ENABLE,
    input  logic              CLR,
    input  logic              STALL_EN,
    input  logic              AXIS_S_TVALID,
    output logic              AXIS_S_TREADY,
    input  logic [TDATAW-1:0] AXIS_S_TDATA,
    input  logic              AXIS_S_TLAST,
    input  logic [TIDW-1:0]   AXIS_S_TID,
    input  logic [TDESTW-1:0] AXIS_S_TDEST,
    output logic [CNTW-1:0]   PKT_CNT,
    output logic [CNTW-1:0]   ERR_CNT,
    output logic [CNTW-1:0]   BEAT_CNT,
    output logic [TDATAW-1:0] CHECKSUM,
    output logic [TIDW-1:0]   LAST_TID,
    output logic [1:0]        LAST_ERR,
    output logic              PKT_DONE,
    output logic              BUSY
);

    localparam int BW = $clog2(MAX_BEATS + 1);

    sink_state_t       state_q, state_d;
    sink_err_t         err_q, err_new, done_code;
    logic              tready_q, stall_bit;
    logic [TIDW-1:0]   tid_q;
    logic [BW-1:0]     beats_q;
    logic [TDATAW-1:0] acc_q, acc_next;
    logic [CNTW-1:0]   pkt_cnt_q, err_cnt_q, beat_cnt_q;
    logic [TDATAW-1:0] checksum_q;
    logic [TIDW-1:0]   last_tid_q;
    sink_err_t         last_err_q;
    logic              pkt_done_q;
    logic              beat_ok, done_good, done_bad;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    lfsr #(
        .LFSR_DW     (LFSR_DW),
        .LFSR_DEFAULT(LFSR_DEFAULT)
    ) u_stall_lfsr (
        .CLK  (CLK),
        .RST_N(RST_N),
        .EN   (STALL_EN),
        .BIT_O(stall_bit)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (CLR) begin
            state_d = ST_IDLE;
        end else if (beat_ok) begin
            case (state_q)
                ST_IDLE: if (!AXIS_S_TLAST) state_d = (err_new != ERR_NONE) ? ST_DROP : ST_BODY;
                ST_BODY: begin
                    if (AXIS_S_TLAST)                state_d = ST_IDLE;
                    else if (err_new != ERR_NONE)    state_d = ST_DROP;
                end
                ST_DROP: if (AXIS_S_TLAST) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Beat decode: error classification (dest > TID > length) and completion type
    always_comb begin
        beat_ok   = AXIS_S_TVALID & tready_q;
        err_new   = ERR_NONE;
        done_good = 1'b0;
        done_bad  = 1'b0;
        done_code = err_q;
        acc_next  = (state_q == ST_IDLE) ? AXIS_S_TDATA : (acc_q ^ AXIS_S_TDATA);
        case (state_q)
            ST_IDLE: if (AXIS_S_TDEST != TDESTW'(NODE_ID)) err_new = ERR_DEST;
            ST_BODY: begin
                if (AXIS_S_TDEST != TDESTW'(NODE_ID)) err_new = ERR_DEST;
                else if (AXIS_S_TID != tid_q)          err_new = ERR_TID;
                else if (beats_q == BW'(MAX_BEATS))    err_new = ERR_LEN;
            end
            default: err_new = ERR_NONE;
        endcase
        if (beat_ok && AXIS_S_TLAST) begin
            if (state_q == ST_DROP) begin
                done_bad = 1'b1;
            end else if (err_new != ERR_NONE) begin
                done_bad  = 1'b1;
                done_code = err_new;
            end else begin
                done_good = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tready_q   <= 1'b0;
            tid_q      <= '0;
            beats_q    <= '0;
            acc_q      <= '0;
            err_q      <= ERR_NONE;
            pkt_cnt_q  <= '0;
            err_cnt_q  <= '0;
            beat_cnt_q <= '0;
            checksum_q <= '0;
            last_tid_q <= '0;
            last_err_q <= ERR_NONE;
            pkt_done_q <= 1'b0;
        end else begin
            tready_q <= ENABLE & ~CLR & ~(STALL_EN & stall_bit);
            if (CLR) begin
                tid_q      <= '0;
                beats_q    <= '0;
                acc_q      <= '0;
                err_q      <= ERR_NONE;
                pkt_cnt_q  <= '0;
                err_cnt_q  <= '0;
                beat_cnt_q <= '0;
                checksum_q <= '0;
                last_tid_q <= '0;
                last_err_q <= ERR_NONE;
                pkt_done_q <= 1'b0;
            end else begin
                pkt_done_q <= done_good | done_bad;
                if (beat_ok) begin
                    beat_cnt_q <= sat_inc(beat_cnt_q);
                    acc_q      <= acc_next;
                    if (state_q == ST_IDLE) begin
                        tid_q   <= AXIS_S_TID;
                        beats_q <= BW'(1);
                    end else if (state_q == ST_BODY && err_new == ERR_NONE) begin
                        beats_q <= beats_q + 1'b1;
                    end
                    if (err_new != ERR_NONE) err_q <= err_new;
                end
                if (done_good) begin
                    pkt_cnt_q  <= sat_inc(pkt_cnt_q);
                    checksum_q <= acc_next;
                    last_tid_q <= (state_q == ST_IDLE) ? AXIS_S_TID : tid_q;
                end
                if (done_bad) begin
                    err_cnt_q  <= sat_inc(err_cnt_q);
                    last_err_q <= done_code;
                end
            end
        end
    end

    assign AXIS_S_TREADY = tready_q;
    assign PKT_CNT       = pkt_cnt_q;
    assign ERR_CNT       = err_cnt_q;
    assign BEAT_CNT      = beat_cnt_q;
    assign CHECKSUM      = checksum_q;
    assign LAST_TID      = last_tid_q;
    assign LAST_ERR      = last_err_q;
    assign PKT_DONE      = pkt_done_q;
    assign BUSY          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axis_sink_checker.sv
// Directed bench for axis_sink_checker: framing errors, length limit, CLR, ENABLE, reset, stall traffic.
// Inputs driven and outputs sampled on the falling edge.
// Backpressure: every beat waits for TREADY within a bounded cycle budget.
module tb_axis_sink_checker;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        ENABLE = 1'b0;
    logic        CLR = 1'b0;
    logic        STALL_EN = 1'b0;
    logic        TVALID = 1'b0;
    logic        TLAST = 1'b0;
    logic [31:0] TDATA = '0;
    logic [1:0]  TID = '0;
    logic [3:0]  TDEST = '0;
    logic        TREADY;
    logic [15:0] PKT_CNT, ERR_CNT, BEAT_CNT;
    logic [31:0] CHECKSUM;
    logic [1:0]  LAST_TID, LAST_ERR;
    logic        PKT_DONE, BUSY;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int low_cnt  = 0;

    axis_sink_checker dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .ENABLE       (ENABLE),
        .CLR          (CLR),
        .STALL_EN     (STALL_EN),
        .AXIS_S_TVALID(TVALID),
        .AXIS_S_TREADY(TREADY),
        .AXIS_S_TDATA (TDATA),
        .AXIS_S_TLAST (TLAST),
        .AXIS_S_TID   (TID),
        .AXIS_S_TDEST (TDEST),
        .PKT_CNT      (PKT_CNT),
        .ERR_CNT      (ERR_CNT),
        .BEAT_CNT     (BEAT_CNT),
        .CHECKSUM     (CHECKSUM),
        .LAST_TID     (LAST_TID),
        .LAST_ERR     (LAST_ERR),
        .PKT_DONE     (PKT_DONE),
        .BUSY         (BUSY)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (PKT_DONE) done_cnt++;
        if (STALL_EN && !TREADY) low_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the beat is accepted
    task automatic send(input logic [31:0] d, input bit last, input logic [1:0] tid,
                        input logic [3:0] dest);
        bit rdy;
        int n = 0;
        TVALID = 1'b1;
        TDATA  = d;
        TLAST  = last;
        TID    = tid;
        TDEST  = dest;
        forever begin
            rdy = TREADY;
            @(posedge CLK);
            if (rdy) break;
            @(negedge CLK);
            n++;
            if (n > 200) begin
                chk("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(negedge CLK);
        TVALID = 1'b0;
        TLAST  = 1'b0;
    endtask

    task automatic do_clr();
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        int total;
        int base;
        int len;
        logic [31:0] x;
        logic [31:0] d;
        logic [1:0]  tid;

        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst_tready", TREADY, 0);
        chk("rst_pkt", PKT_CNT, 0);
        chk("rst_err", ERR_CNT, 0);
        chk("rst_beat", BEAT_CNT, 0);
        chk("rst_csum", CHECKSUM, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", PKT_DONE, 0);
        ENABLE = 1'b1;
        RST_N  = 1'b1;
        @(negedge CLK);
        chk("first_tready", TREADY, 1);

        // 4-beat good packet
        send(32'h1, 0, 2'd1, 4'd0);
        chk("p4_busy", BUSY, 1);
        send(32'h2, 0, 2'd1, 4'd0);
        send(32'h4, 0, 2'd1, 4'd0);
        send(32'h8, 1, 2'd1, 4'd0);
        chk("p4_done", PKT_DONE, 1);
        chk("p4_pkt", PKT_CNT, 1);
        chk("p4_csum", CHECKSUM, 32'hF);
        chk("p4_tid", LAST_TID, 1);
        chk("p4_beat", BEAT_CNT, 4);
        chk("p4_idle", BUSY, 0);
        @(negedge CLK);
        chk("p4_done_pulse", PKT_DONE, 0);

        // CLR zeroes status
        do_clr();
        chk("clr_pkt", PKT_CNT, 0);
        chk("clr_csum", CHECKSUM, 0);
        chk("clr_beat", BEAT_CNT, 0);

        // Single-beat wrong destination
        send(32'h55, 1, 2'd0, 4'd1);
        chk("dest_err", ERR_CNT, 1);
        chk("dest_code", LAST_ERR, 1);
        chk("dest_pkt", PKT_CNT, 0);
        chk("dest_idle", BUSY, 0);
        chk("dest_done", PKT_DONE, 1);

        // 20 beats: overlength at beat 17, rest dropped
        do_clr();
        for (int i = 1; i <= 20; i++) begin
            send(32'(i), i == 20, 2'd1, 4'd0);
            if (i == 17) begin
                chk("len_drop_busy", BUSY, 1);
                chk("len_no_err_yet", ERR_CNT, 0);
            end
        end
        chk("len_err", ERR_CNT, 1);
        chk("len_code", LAST_ERR, 3);
        chk("len_beat", BEAT_CNT, 20);
        chk("len_pkt", PKT_CNT, 0);
        chk("len_csum", CHECKSUM, 0);

        // Exactly MAX_BEATS is legal
        for (int i = 1; i <= 16; i++) send(32'(i), i == 16, 2'd2, 4'd0);
        chk("max_pkt", PKT_CNT, 1);
        chk("max_csum", CHECKSUM, 32'h10);
        chk("max_tid", LAST_TID, 2);
        chk("max_beat", BEAT_CNT, 36);
        chk("max_err", ERR_CNT, 1);

        // TID change mid-packet
        do_clr();
        send(32'hA5, 1, 2'd0, 4'd0);
        chk("tid_pre_csum", CHECKSUM, 32'hA5);
        send(32'h1, 0, 2'd1, 4'd0);
        send(32'h2, 0, 2'd2, 4'd0);
        send(32'h4, 1, 2'd2, 4'd0);
        chk("tid_code", LAST_ERR, 2);
        chk("tid_err", ERR_CNT, 1);
        chk("tid_csum", CHECKSUM, 32'hA5);
        chk("tid_pkt", PKT_CNT, 1);
        // Dest and TID both bad on the TLAST beat: dest wins, completes at once
        send(32'h1, 0, 2'd1, 4'd0);
        send(32'h2, 1, 2'd2, 4'd5);
        chk("prio_code", LAST_ERR, 1);
        chk("prio_err", ERR_CNT, 2);
        chk("prio_idle", BUSY, 0);
        send(32'h7, 0, 2'd3, 4'd0);
        send(32'h8, 1, 2'd3, 4'd0);
        chk("after_err_pkt", PKT_CNT, 2);
        chk("after_err_csum", CHECKSUM, 32'hF);
        chk("after_err_tid", LAST_TID, 3);

        // ENABLE low mid-packet holds state
        do_clr();
        send(32'h3, 0, 2'd1, 4'd0);
        ENABLE = 1'b0;
        @(negedge CLK);
        chk("en_tready", TREADY, 0);
        chk("en_busy", BUSY, 1);
        TVALID = 1'b1;
        TDATA  = 32'h5;
        TLAST  = 1'b1;
        TID    = 2'd1;
        TDEST  = 4'd0;
        repeat (3) @(negedge CLK);
        chk("en_hold_beat", BEAT_CNT, 1);
        ENABLE = 1'b1;
        send(32'h5, 1, 2'd1, 4'd0);
        chk("en_pkt", PKT_CNT, 1);
        chk("en_csum", CHECKSUM, 32'h6);

        // CLR mid-packet with a beat presented at the CLR edge
        send(32'h9, 0, 2'd2, 4'd0);
        send(32'h9, 0, 2'd2, 4'd0);
        TVALID = 1'b1;
        TDATA  = 32'h9;
        TLAST  = 1'b1;
        CLR    = 1'b1;
        @(negedge CLK);
        CLR    = 1'b0;
        TVALID = 1'b0;
        TLAST  = 1'b0;
        chk("clrmid_pkt", PKT_CNT, 0);
        chk("clrmid_beat", BEAT_CNT, 0);
        chk("clrmid_busy", BUSY, 0);
        chk("clrmid_tready", TREADY, 0);
        chk("clrmid_done", PKT_DONE, 0);
        @(negedge CLK);
        send(32'h30, 0, 2'd1, 4'd0);
        send(32'h03, 1, 2'd1, 4'd0);
        chk("clrmid_next_pkt", PKT_CNT, 1);
        chk("clrmid_next_beat", BEAT_CNT, 2);
        chk("clrmid_next_csum", CHECKSUM, 32'h33);

        // Random packets under pseudo-random stall
        do_clr();
        STALL_EN = 1'b1;
        base  = done_cnt;
        total = 0;
        x     = '0;
        for (int p = 0; p < 100; p++) begin
            len = $urandom_range(1, 8);
            tid = 2'($urandom_range(0, 3));
            x   = '0;
            for (int b = 0; b < len; b++) begin
                d = $urandom;
                x = x ^ d;
                send(d, b == len - 1, tid, 4'd0);
            end
            total += len;
            if ($urandom_range(0, 3) == 0) @(negedge CLK);
        end
        @(negedge CLK);
        @(negedge CLK);
        chk("stall_pkt", PKT_CNT, 100);
        chk("stall_beat", BEAT_CNT, 32'(total));
        chk("stall_csum", CHECKSUM, x);
        chk("stall_err", ERR_CNT, 0);
        chk("stall_done_pulses", 32'(done_cnt - base), 100);
        chk("stall_saw_low", 32'(low_cnt != 0), 1);
        STALL_EN = 1'b0;
        @(negedge CLK);

        // Reset mid-packet
        do_clr();
        send(32'hEE, 0, 2'd1, 4'd0);
        chk("rstmid_busy_pre", BUSY, 1);
        RST_N = 1'b0;
        #1;
        chk("rstmid_busy", BUSY, 0);
        chk("rstmid_tready", TREADY, 0);
        chk("rstmid_beat", BEAT_CNT, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("rstmid_tready_back", TREADY, 1);
        send(32'h42, 1, 2'd2, 4'd0);
        chk("rstmid_pkt", PKT_CNT, 1);
        chk("rstmid_csum", CHECKSUM, 32'h42);
        chk("rstmid_beat_after", BEAT_CNT, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=0 exp=1");
        $fatal(1, "timeout");
    end

endmodule
